// File: rtl/s_pea_out_collector.sv
// ---------------------------------------------------------------------------
// s_pea_out_collector
//
// Streaming-mode output stage sitting directly behind a boundary PE of the
// PEA. Registered PE results are captured into a small first-word-fall-
// through FIFO and presented on a valid/ready stream port towards the stream
// DMA. The PEA-wide advance enable (pea_ready_o) is derived from FIFO
// occupancy so the whole array stalls when the consumer back-pressures.
// A programmed number of beats is collected per transfer; the final beat is
// tagged with out_last_o and completion is signalled with a done_o pulse.
//
// Optional build macro:
//   S_PEA_OUT_COLLECT_STATS_EN - when defined, stall_cnt_o counts RUN cycles
//   in which the PEA was held off purely because the FIFO was full.
//   When undefined, the counter is absent and stall_cnt_o reads 0.
//
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   start_i      one-cycle start pulse, honoured only in IDLE
//   cfg_len_i    beats to collect, sampled with start_i
//   pe_res_i     result from the boundary PE output register
//   pe_valid_i   valid from the boundary PE
//   pea_ready_o  global PEA advance enable
//   out_data_o   stream data (FIFO head, or last popped word when empty)
//   out_valid_o  stream valid
//   out_ready_i  stream ready from the consumer
//   out_last_o   marks the final beat of the transfer
//   busy_o       high while collecting or draining
//   done_o       one-cycle completion pulse
//   stall_cnt_o  back-pressure stall statistics
// ---------------------------------------------------------------------------
module s_pea_out_collector #(
   parameter int N_BITS = 32,
   parameter int DEPTH  = 4,
   parameter int LEN_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  cfg_len_i,
   input  logic [N_BITS-1:0] pe_res_i,
   input  logic              pe_valid_i,
   output logic              pea_ready_o,
   output logic [N_BITS-1:0] out_data_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              out_last_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [31:0]       stall_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   // One extra bit so a completely full FIFO is distinguishable from empty.
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_reg;
   state_t             state_next;

   logic [LEN_W-1:0]   len_reg;
   logic [LEN_W-1:0]   in_cnt_reg;
   logic [LEN_W-1:0]   out_cnt_reg;

   logic [N_BITS-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [N_BITS-1:0]  last_data_reg;

   logic               start_ok;
   logic               accept;
   logic               pop;
   logic               in_final;
   logic               out_final;

   // ------------------------------------------------------------------------
   // Handshake decode. pea_ready_o looks only at registered state, so there
   // is no combinational path from the stream side back into the PEA.
   // ------------------------------------------------------------------------
   assign start_ok    = (state_reg == ST_IDLE) & start_i;
   assign pea_ready_o = (state_reg == ST_RUN) & (count_reg < FULL_LVL) &
                        (in_cnt_reg < len_reg);
   assign out_valid_o = (count_reg != '0);
   assign accept      = pe_valid_i & pea_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   // in_cnt < len whenever an accept is possible, so the increment cannot wrap.
   assign in_final    = accept & ((in_cnt_reg + LEN_W'(1)) == len_reg);
   assign out_last_o  = out_valid_o & (out_cnt_reg == (len_reg - LEN_W'(1)));
   assign out_final   = pop & out_last_o;

   assign busy_o      = (state_reg == ST_RUN) | (state_reg == ST_DRAIN);
   assign done_o      = (state_reg == ST_DONE);

   // First-word-fall-through head. While empty the last popped word is kept
   // on the bus rather than whatever stale entry the pointer lands on.
   assign out_data_o  = out_valid_o ? mem[rd_ptr_reg] : last_data_reg;

   // ------------------------------------------------------------------------
   // FSM next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start_i) begin
               state_next = (cfg_len_i != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            // The final accept and the final pop can only share a cycle if
            // the last beat bypassed the FIFO; handled for completeness.
            if (in_final) begin
               state_next = out_final ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_final) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, counters and FIFO bookkeeping
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg     <= ST_IDLE;
         len_reg       <= '0;
         in_cnt_reg    <= '0;
         out_cnt_reg   <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         last_data_reg <= '0;
      end else begin
         state_reg <= state_next;

         if (start_ok) begin
            len_reg     <= cfg_len_i;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
         end else begin
            if (accept) begin
               in_cnt_reg <= in_cnt_reg + LEN_W'(1);
            end
            if (pop) begin
               out_cnt_reg <= out_cnt_reg + LEN_W'(1);
            end
         end

         if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
            last_data_reg <= mem[rd_ptr_reg];
         end

         // Push and pop in the same cycle leave the occupancy unchanged.
         case ({accept, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         mem[wr_ptr_reg] <= pe_res_i;
      end
   end

   // ------------------------------------------------------------------------
   // Back-pressure statistics
   // ------------------------------------------------------------------------
`ifdef S_PEA_OUT_COLLECT_STATS_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt_reg <= '0;
      end else if (start_ok) begin
         stall_cnt_reg <= '0;
      end else if ((state_reg == ST_RUN) && (count_reg == FULL_LVL) &&
                   (in_cnt_reg < len_reg) && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_s_pea_out_collector.sv
// ---------------------------------------------------------------------------
// tb_s_pea_out_collector
//
// Self-checking bench for s_pea_out_collector. A driver issues start pulses,
// PE beats and consumer ready; every accepted beat is pushed into a
// scoreboard queue together with its expected last flag. A separate monitor
// compares the stream port against the queue head every cycle and pops on
// each handshake. The expected occupancy, stall enable, busy and done
// behaviour are all derived from the queue and a handful of model variables.
// ---------------------------------------------------------------------------
module tb_s_pea_out_collector;

   localparam int N_BITS = 32;
   localparam int DEPTH  = 4;
   localparam int LEN_W  = 16;

   logic              clk_i;
   logic              rst_n_i;
   logic              start_i;
   logic [LEN_W-1:0]  cfg_len_i;
   logic [N_BITS-1:0] pe_res_i;
   logic              pe_valid_i;
   logic              pea_ready_o;
   logic [N_BITS-1:0] out_data_o;
   logic              out_valid_o;
   logic              out_ready_i;
   logic              out_last_o;
   logic              busy_o;
   logic              done_o;
   logic [31:0]       stall_cnt_o;

   s_pea_out_collector #(
      .N_BITS (N_BITS),
      .DEPTH  (DEPTH),
      .LEN_W  (LEN_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .start_i     (start_i),
      .cfg_len_i   (cfg_len_i),
      .pe_res_i    (pe_res_i),
      .pe_valid_i  (pe_valid_i),
      .pea_ready_o (pea_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_last_o  (out_last_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .stall_cnt_o (stall_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] d;
      logic        last;
   } beat_t;

   beat_t       sb[$];
   int          n_checks;
   int          n_fail;
   bit          mon_en;
   int          occ_snap;     // FIFO occupancy before the coming edge
   bit          busy_exp;
   bit          done_exp;
   int          acc;          // beats accepted in the current transfer
   int          cur_len;
   int          stall_model;
   logic [31:0] last_popped;
   int          xfer_id;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (xfer %0d, t=%0t): got 0x%0h expected 0x%0h",
                  name, xfer_id, $time, act, exp);
      end
   endfunction

   // ------------------------------------------------------------------------
   // Monitor: stream side against the scoreboard, plus busy/done.
   // ------------------------------------------------------------------------
   always @(negedge clk_i) begin
      #1;
      if (mon_en) begin
         logic        exp_valid;
         logic [31:0] exp_data;
         logic        exp_last;
         exp_valid = (sb.size() != 0);
         exp_data  = exp_valid ? sb[0].d : last_popped;
         exp_last  = exp_valid ? sb[0].last : 1'b0;
         chk("out_valid", out_valid_o, exp_valid);
         chk("out_data",  out_data_o,  exp_data);
         chk("out_last",  out_last_o,  exp_last);
         chk("done",      done_o,      done_exp);
         chk("busy",      busy_o,      busy_exp);
         done_exp = 1'b0;
         occ_snap = sb.size();
         if (out_valid_o && out_ready_i && exp_valid) begin
            beat_t b;
            b = sb.pop_front();
            last_popped = b.d;
            $display("xfer %0d: beat out data=0x%0h last=%0b", xfer_id, b.d, b.last);
            if (b.last) begin
               done_exp = 1'b1;
               busy_exp = 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Reset: outputs must clear without waiting for a clock edge.
   // ------------------------------------------------------------------------
   task automatic do_reset();
      @(negedge clk_i);
      rst_n_i    = 1'b0;
      mon_en     = 1'b0;
      start_i    = 1'b0;
      pe_valid_i = 1'b0;
      #1;
      chk("rst pea_ready", pea_ready_o, 0);
      chk("rst out_valid", out_valid_o, 0);
      chk("rst out_data",  out_data_o,  0);
      chk("rst out_last",  out_last_o,  0);
      chk("rst busy",      busy_o,      0);
      chk("rst done",      done_o,      0);
      chk("rst stall_cnt", stall_cnt_o, 0);
      sb.delete();
      busy_exp    = 1'b0;
      done_exp    = 1'b0;
      acc         = 0;
      cur_len     = 0;
      stall_model = 0;
      last_popped = '0;
      occ_snap    = 0;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      mon_en  = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   // One transfer. valid_pct/ready_pct give per-cycle probabilities;
   // ready_hold forces out_ready_i low for the first cycles; abort_after>0
   // leaves the task after that many accepts; restart pulses a second start
   // (len 5) mid-transfer which must be ignored.
   // ------------------------------------------------------------------------
   task automatic run_xfer(input int len, input int valid_pct, input int ready_pct,
                           input int ready_hold, input bit seq_data,
                           input int abort_after, input bit restart);
      int  budget;
      int  cyc;
      bit  finished;
      budget   = 20 * len + 60;
      finished = 1'b0;
      xfer_id++;
      $display("xfer %0d: start len=%0d", xfer_id, len);
      for (cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk_i);
         start_i    = (cyc == 0) || (restart && cyc == 3);
         cfg_len_i  = (restart && cyc == 3) ? LEN_W'(5) : LEN_W'(len);
         pe_valid_i = ($urandom_range(99) < valid_pct);
         pe_res_i   = seq_data ? 32'(acc + 1) : $urandom;
         out_ready_i = (cyc >= ready_hold) && ($urandom_range(99) < ready_pct);
         #2;
         chk("pea_ready", pea_ready_o,
             busy_exp && (occ_snap < DEPTH) && (acc < cur_len));
`ifdef S_PEA_OUT_COLLECT_STATS_EN
         chk("stall_cnt", stall_cnt_o, stall_model);
`else
         chk("stall_cnt", stall_cnt_o, 0);
`endif
         if (busy_exp && (occ_snap == DEPTH) && (acc < cur_len)) begin
            stall_model++;
         end
         if (pe_valid_i && pea_ready_o) begin
            if (acc >= cur_len) begin
               n_checks++;
               n_fail++;
               $display("FAIL extra_accept (xfer %0d): got beat %0d expected at most %0d",
                        xfer_id, acc + 1, cur_len);
            end else begin
               beat_t b;
               b.d    = pe_res_i;
               b.last = (acc == cur_len - 1);
               sb.push_back(b);
               acc++;
            end
         end
         if (cyc == 0) begin
            cur_len     = len;
            acc         = 0;
            stall_model = 0;
            busy_exp    = (len != 0);
            done_exp    = (len == 0);
         end
         if (abort_after > 0 && acc == abort_after) begin
            finished = 1'b1;
            break;
         end
         if (cyc > 0 && !busy_exp && !done_exp) begin
            finished = 1'b1;
            break;
         end
      end
      start_i    = 1'b0;
      pe_valid_i = 1'b0;
      n_checks++;
      if (!finished) begin
         n_fail++;
         $display("FAIL timeout (xfer %0d): got %0d beats pending expected 0",
                  xfer_id, sb.size());
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      mon_en      = 1'b0;
      xfer_id     = 0;
      rst_n_i     = 1'b1;
      start_i     = 1'b0;
      cfg_len_i   = '0;
      pe_res_i    = '0;
      pe_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      last_popped = '0;

      do_reset();

      // Streaming without back-pressure, data 1..8.
      run_xfer(8, 100, 100, 0, 1'b1, 0, 1'b0);
      // Consumer stalls for 10 cycles; FIFO fills and the PEA must stall.
      run_xfer(10, 100, 100, 10, 1'b1, 0, 1'b0);
      // Zero length completes immediately with no beats.
      run_xfer(0, 100, 100, 0, 1'b1, 0, 1'b0);
      // Long random run with toggling ready around the full boundary.
      run_xfer(1000, 90, 55, 0, 1'b0, 0, 1'b0);
      // Reset in the middle of a transfer, then a short fresh one.
      run_xfer(8, 100, 30, 0, 1'b1, 3, 1'b0);
      do_reset();
      run_xfer(2, 100, 100, 0, 1'b1, 0, 1'b0);
      // A second start during RUN must not disturb the running transfer.
      run_xfer(8, 100, 100, 0, 1'b1, 0, 1'b1);
      // A few short random transfers.
      for (int i = 0; i < 6; i++) begin
         run_xfer($urandom_range(1, 20), 75, 60, $urandom_range(0, 6), 1'b0, 0, 1'b0);
      end

      repeat (3) @(negedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
